// File: rtl/spu_imm_encoder.sv
// ----------------------------------------------------------------------------
// spu_imm_encoder
//
// Packs a signed immediate into the immediate bit field of an SPU
// instruction word. This is the inverse of the immediate select/sign-extend
// stage: a word produced here decodes back to the original value.
// The block also range-checks the value against the chosen format and keeps
// a saturating count of the range errors it has delivered downstream.
//
// The datapath is a two-stage valid/ready pipeline:
//   S1 holds the accepted beat (value, format, base word).
//   S2 holds the merged instruction word and its range flag, and drives the
//   outputs.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   input beat valid
//   in_ready   encoder can accept a beat this cycle
//   imm_val    immediate value, signed two's complement
//   select     format: 00 I7 [17:11], 01 I10 [17:8], 10 I16 [24:9],
//              11 I18 [24:7] (I18 is unsigned)
//   base_inst  instruction word; its immediate field bits are replaced
//   out_valid  encoded word valid
//   out_ready  downstream accepts the word
//   inst       encoded instruction word
//   range_err  value did not fit the format (qualified by out_valid)
//   err_clr    synchronous clear of err_count
//   err_count  saturating count of range errors delivered downstream
// ----------------------------------------------------------------------------
module spu_imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      imm_val,
    input  logic [1:0]       select,
    input  logic [31:0]      base_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             range_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] SEL_I7  = 2'b00;
    localparam logic [1:0] SEL_I10 = 2'b01;
    localparam logic [1:0] SEL_I16 = 2'b10;
    localparam logic [1:0] SEL_I18 = 2'b11;

    localparam logic [31:0] MASK_I7  = 32'h0003_F800;
    localparam logic [31:0] MASK_I10 = 32'h0003_FF00;
    localparam logic [31:0] MASK_I16 = 32'h01FF_FE00;
    localparam logic [31:0] MASK_I18 = 32'h01FF_FF80;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1 registers
    logic              s1_valid_q, s1_valid_d;
    logic [31:0]       s1_imm_q,   s1_imm_d;
    logic [1:0]        s1_sel_q,   s1_sel_d;
    logic [31:0]       s1_base_q,  s1_base_d;

    // Stage 2 registers
    logic              s2_valid_q, s2_valid_d;
    logic [31:0]       s2_inst_q,  s2_inst_d;
    logic              s2_err_q,   s2_err_d;

    // Error counter
    logic [CNT_W-1:0]  err_count_q, err_count_d;

    // Handshake and datapath intermediates
    logic              s2_advance;
    logic              s2_load_en;
    logic              s1_advance;
    logic              s1_load;
    logic [31:0]       field_mask;
    logic [31:0]       field_val;
    logic              s1_range_err;
    logic [31:0]       merged_inst;

    // Pipeline handshake. S2 can take a new word when it is empty or its
    // current word leaves this cycle; S1 can take a beat under the same rule
    // one stage later. in_ready depends only on state and out_ready, never on
    // in_valid, so upstream logic cannot form a combinational loop through us.
    always_comb begin
        s2_advance = s2_valid_q && out_ready;
        s2_load_en = !s2_valid_q || s2_advance;
        s1_advance = s1_valid_q && s2_load_en;
        in_ready   = !s1_valid_q || s1_advance;
        s1_load    = in_valid && in_ready;
    end

    // Field geometry and range check for the beat sitting in S1.
    // The signed formats fit when every bit above the field's sign bit equals
    // that sign bit (all ones or all zeros). I18 is unsigned, so any set bit
    // above the field, including a negative sign, is an error.
    // Out-of-range values are still truncated into the field.
    always_comb begin
        field_mask   = 32'h0000_0000;
        field_val    = 32'h0000_0000;
        s1_range_err = 1'b0;
        case (s1_sel_q)
            SEL_I7: begin
                field_mask   = MASK_I7;
                field_val    = {14'b0, s1_imm_q[6:0], 11'b0};
                s1_range_err = !((&s1_imm_q[31:6]) || !(|s1_imm_q[31:6]));
            end
            SEL_I10: begin
                field_mask   = MASK_I10;
                field_val    = {14'b0, s1_imm_q[9:0], 8'b0};
                s1_range_err = !((&s1_imm_q[31:9]) || !(|s1_imm_q[31:9]));
            end
            SEL_I16: begin
                field_mask   = MASK_I16;
                field_val    = {7'b0, s1_imm_q[15:0], 9'b0};
                s1_range_err = !((&s1_imm_q[31:15]) || !(|s1_imm_q[31:15]));
            end
            SEL_I18: begin
                field_mask   = MASK_I18;
                field_val    = {7'b0, s1_imm_q[17:0], 7'b0};
                s1_range_err = |s1_imm_q[31:18];
            end
            default: begin
                field_mask   = 32'h0000_0000;
                field_val    = 32'h0000_0000;
                s1_range_err = 1'b0;
            end
        endcase
        merged_inst = (s1_base_q & ~field_mask) | field_val;
    end

    // Next-state for both stages. Data registers only load on a real
    // transfer, so a stalled S2 keeps inst and range_err stable and an
    // empty pipeline keeps its post-reset zeros.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_sel_d   = s1_sel_q;
        s1_base_d  = s1_base_q;
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;

        if (s1_load) begin
            s1_imm_d  = imm_val;
            s1_sel_d  = select;
            s1_base_d = base_inst;
        end
        if (s1_load || s1_advance) begin
            s1_valid_d = s1_load;
        end

        if (s2_load_en) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_advance) begin
            s2_inst_d = merged_inst;
            s2_err_d  = s1_range_err;
        end
    end

    // Error counter: clear wins over a same-cycle increment, and the count
    // sticks at its maximum instead of wrapping.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (s2_advance && s2_err_q && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_ONE;
        end
    end

    // State registers with synchronous reset; reset discards in-flight beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_imm_q    <= 32'h0000_0000;
            s1_sel_q    <= 2'b00;
            s1_base_q   <= 32'h0000_0000;
            s2_valid_q  <= 1'b0;
            s2_inst_q   <= 32'h0000_0000;
            s2_err_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_imm_q    <= s1_imm_d;
            s1_sel_q    <= s1_sel_d;
            s1_base_q   <= s1_base_d;
            s2_valid_q  <= s2_valid_d;
            s2_inst_q   <= s2_inst_d;
            s2_err_q    <= s2_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign inst      = s2_inst_q;
    assign range_err = s2_err_q;
    assign err_count = err_count_q;

endmodule
